// File: rtl/cpu_pipe_ctrl_pkg.sv
// Shared types for the 4-stage pipeline control: opcodes, the EX/WB payload and its bubble constant,
// and the stall/flush sequencer state encoding.
package cpu_pipe_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_NA   = 4'h0,
    OP_ALU  = 4'h1,
    OP_LD   = 4'h2,
    OP_ST   = 4'h3,
    OP_BR   = 4'h4,
    OP_MUL  = 4'h5,
    OP_MULH = 4'h6
  } opcode_t;

  typedef struct packed {
    opcode_t     opcode;
    logic [4:0]  rd;
    logic [31:0] result;
    logic        wr_en;
  } ex_wb_t;

  localparam ex_wb_t EX_WB_BUBBLE = '{opcode: OP_NA, default: '0};

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] MC_WAIT = 1'b1;

  // MUL class runs on the fixed-latency multicycle unit
  function automatic logic is_multicycle(opcode_t op);
    return (op == OP_MUL) || (op == OP_MULH);
  endfunction

endpackage

// File: rtl/cpu_pipe_ctrl_if.sv
// EX-stage status in, pipeline-register enable/flush controls out.
interface cpu_pipe_ctrl_if #(
  parameter int unsigned STALL_CNT_W = 16
);
  cpu_pipe_ctrl_pkg::opcode_t ex_opcode;
  logic                       branch_taken;
  logic                       ext_stall;
  logic                       if_id_en;
  logic                       if_id_flush;
  logic                       id_ex_en;
  logic                       id_ex_flush;
  logic                       ex_wb_en;
  logic                       ex_wb_bubble;
  logic                       mc_start;
  logic                       busy;
  logic [STALL_CNT_W-1:0]     stall_cnt;

  modport master (
    output ex_opcode, branch_taken, ext_stall,
    input  if_id_en, if_id_flush, id_ex_en, id_ex_flush,
           ex_wb_en, ex_wb_bubble, mc_start, busy, stall_cnt
  );

  modport slave (
    input  ex_opcode, branch_taken, ext_stall,
    output if_id_en, if_id_flush, id_ex_en, id_ex_flush,
           ex_wb_en, ex_wb_bubble, mc_start, busy, stall_cnt
  );
endinterface

// File: rtl/cpu_pipe_ctrl_sat_counter.sv
// Saturating up-counter; holds at all-ones.
module cpu_pipe_ctrl_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/cpu_pipe_ctrl.sv
// Stall/flush sequencer for IF/ID, ID/EX and EX/WB: multicycle EX hold, branch flush, global memory stall.
// Priority: ext_stall > multicycle > branch.
module cpu_pipe_ctrl
  import cpu_pipe_ctrl_pkg::*;
#(
  parameter int unsigned MC_LAT      = 4,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  cpu_pipe_ctrl_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(MC_LAT + 1);

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic w_if_id_en, w_if_id_flush, w_id_ex_en, w_id_ex_flush;
  logic w_ex_wb_en, w_ex_wb_bubble, w_mc_start, w_busy;
  logic [STALL_CNT_W-1:0] w_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_if_id_en     = 1'b0;
    w_if_id_flush  = 1'b0;
    w_id_ex_en     = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_ex_wb_en     = 1'b0;
    w_ex_wb_bubble = 1'b0;
    w_mc_start     = 1'b0;
    w_busy         = 1'b0;

    if (!reset) begin
      w_busy = (r_state == MC_WAIT);
      if (bus.ext_stall) begin
        // Multicycle unit keeps running under a global hold; only the capture waits
        if ((r_state == MC_WAIT) && (r_cnt != '0)) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end else begin
        case (r_state)
          RUN: begin
            if (is_multicycle(bus.ex_opcode)) begin
              w_mc_start     = 1'b1;
              w_ex_wb_en     = 1'b1;
              w_ex_wb_bubble = 1'b1;
              w_state_nxt    = MC_WAIT;
              w_cnt_nxt      = CNT_W'(MC_LAT - 1);
            end else begin
              w_if_id_en    = 1'b1;
              w_id_ex_en    = 1'b1;
              w_ex_wb_en    = 1'b1;
              w_if_id_flush = bus.branch_taken;
              w_id_ex_flush = bus.branch_taken;
            end
          end
          MC_WAIT: begin
            w_ex_wb_en = 1'b1;
            if (r_cnt != '0) begin
              w_ex_wb_bubble = 1'b1;
              w_cnt_nxt      = r_cnt - CNT_W'(1);
            end else begin
              w_if_id_en  = 1'b1;
              w_id_ex_en  = 1'b1;
              w_state_nxt = RUN;
            end
          end
          default: begin
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
          end
        endcase
      end
    end
  end

  cpu_pipe_ctrl_sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .i_inc (~w_if_id_en),
    .o_cnt (w_stall_cnt)
  );

  assign bus.if_id_en     = w_if_id_en;
  assign bus.if_id_flush  = w_if_id_flush;
  assign bus.id_ex_en     = w_id_ex_en;
  assign bus.id_ex_flush  = w_id_ex_flush;
  assign bus.ex_wb_en     = w_ex_wb_en;
  assign bus.ex_wb_bubble = w_ex_wb_bubble;
  assign bus.mc_start     = w_mc_start;
  assign bus.busy         = w_busy;
  assign bus.stall_cnt    = w_stall_cnt;
endmodule
